// File: rtl/axim_ctrl_if.sv
// Bundle for the LSU request port and the AXI4-Lite master channels of axim_ctrl.
// The master modport is the controller's view; the slave modport is the environment's.
interface axim_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              hs_ls4axim_val;
    logic              hs_axim4ls_rdy;
    logic [AW-1:0]     i_axim_adr;
    logic [DW-1:0]     i_axim_wdat;
    logic [DW/8-1:0]   i_axim_wen;
    logic              i_axim_ren;
    logic [DW-1:0]     o_axim_rdat;
    logic              o_axim_err;

    logic [AW-1:0]     o_axi_awaddr;
    logic              o_axi_awvalid;
    logic              i_axi_awready;
    logic [DW-1:0]     o_axi_wdata;
    logic [DW/8-1:0]   o_axi_wstrb;
    logic              o_axi_wvalid;
    logic              i_axi_wready;
    logic [1:0]        i_axi_bresp;
    logic              i_axi_bvalid;
    logic              o_axi_bready;
    logic [AW-1:0]     o_axi_araddr;
    logic              o_axi_arvalid;
    logic              i_axi_arready;
    logic [DW-1:0]     i_axi_rdata;
    logic [1:0]        i_axi_rresp;
    logic              i_axi_rvalid;
    logic              o_axi_rready;

    modport master (
        input  hs_ls4axim_val, i_axim_adr, i_axim_wdat, i_axim_wen, i_axim_ren,
        output hs_axim4ls_rdy, o_axim_rdat, o_axim_err,
        output o_axi_awaddr, o_axi_awvalid, input i_axi_awready,
        output o_axi_wdata, o_axi_wstrb, o_axi_wvalid, input i_axi_wready,
        input  i_axi_bresp, i_axi_bvalid, output o_axi_bready,
        output o_axi_araddr, o_axi_arvalid, input i_axi_arready,
        input  i_axi_rdata, i_axi_rresp, i_axi_rvalid, output o_axi_rready
    );

    modport slave (
        output hs_ls4axim_val, i_axim_adr, i_axim_wdat, i_axim_wen, i_axim_ren,
        input  hs_axim4ls_rdy, o_axim_rdat, o_axim_err,
        input  o_axi_awaddr, o_axi_awvalid, output i_axi_awready,
        input  o_axi_wdata, o_axi_wstrb, o_axi_wvalid, output i_axi_wready,
        output i_axi_bresp, i_axi_bvalid, input o_axi_bready,
        input  o_axi_araddr, o_axi_arvalid, output i_axi_arready,
        output i_axi_rdata, i_axi_rresp, i_axi_rvalid, input o_axi_rready
    );
endinterface

// File: rtl/axim_ctrl.sv
// Sequences one held LSU request onto an AXI4-Lite master bus (AW/W/B or AR/R)
// and pulses ready for one cycle on completion, one transaction in flight at a time.
module axim_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic         clk,
    input logic         rst,
    axim_ctrl_if.master bus
);
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_BRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic            awvalid_r, awvalid_s;
    logic            wvalid_r, wvalid_s;
    logic            bready_r, bready_s;
    logic            arvalid_r, arvalid_s;
    logic            rready_r, rready_s;
    logic            rdy_r, rdy_s;
    logic            err_r, err_s;
    logic [DW-1:0]   rdat_r, rdat_s;
    logic [AW-1:0]   adr_r, adr_s;
    logic [DW-1:0]   wdat_r, wdat_s;
    logic [SW-1:0]   wen_r, wen_s;
    logic            aw_done_s, w_done_s;

    // A write channel counts as done once its valid has already dropped or is handshaking now
    assign aw_done_s = ~awvalid_r | bus.i_axi_awready;
    assign w_done_s  = ~wvalid_r  | bus.i_axi_wready;

    // Next-state and next-output decode of the request sequencer
    always_comb begin
        state_s   = state_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        bready_s  = 1'b0;
        arvalid_s = arvalid_r;
        rready_s  = 1'b0;
        rdy_s     = 1'b0;
        err_s     = err_r;
        rdat_s    = rdat_r;
        adr_s     = adr_r;
        wdat_s    = wdat_r;
        wen_s     = wen_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.hs_ls4axim_val) begin
                    adr_s  = bus.i_axim_adr;
                    wdat_s = bus.i_axim_wdat;
                    wen_s  = bus.i_axim_wen;
                    if (bus.i_axim_wen != {SW{1'b0}}) begin
                        state_s   = ST_WADDR;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                    end else if (bus.i_axim_ren) begin
                        state_s   = ST_RADDR;
                        arvalid_s = 1'b1;
                    end else begin
                        // Null request completes without touching the bus
                        state_s = ST_DONE;
                        rdy_s   = 1'b1;
                        err_s   = 1'b0;
                        rdat_s  = {DW{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (awvalid_r && bus.i_axi_awready) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && bus.i_axi_wready) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (aw_done_s && w_done_s) begin
                    state_s  = ST_BRESP;
                    bready_s = 1'b1;
                end else begin
                    state_s = ST_WADDR;
                end
            end
            ST_BRESP: begin
                if (bus.i_axi_bvalid) begin
                    state_s = ST_DONE;
                    rdy_s   = 1'b1;
                    err_s   = (bus.i_axi_bresp != 2'b00);
                end else begin
                    bready_s = 1'b1;
                end
            end
            ST_RADDR: begin
                if (bus.i_axi_arready) begin
                    state_s   = ST_RDATA;
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                end else begin
                    state_s = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (bus.i_axi_rvalid) begin
                    state_s = ST_DONE;
                    rdy_s   = 1'b1;
                    rdat_s  = bus.i_axi_rdata;
                    err_s   = (bus.i_axi_rresp != 2'b00);
                end else begin
                    rready_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bus outputs, latched request fields and completion status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            rdy_r     <= 1'b0;
            err_r     <= 1'b0;
            rdat_r    <= {DW{1'b0}};
            adr_r     <= {AW{1'b0}};
            wdat_r    <= {DW{1'b0}};
            wen_r     <= {SW{1'b0}};
        end else begin
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            bready_r  <= bready_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            rdy_r     <= rdy_s;
            err_r     <= err_s;
            rdat_r    <= rdat_s;
            adr_r     <= adr_s;
            wdat_r    <= wdat_s;
            wen_r     <= wen_s;
        end
    end

    assign bus.hs_axim4ls_rdy = rdy_r;
    assign bus.o_axim_rdat    = rdat_r;
    assign bus.o_axim_err     = err_r;
    assign bus.o_axi_awaddr   = adr_r;
    assign bus.o_axi_awvalid  = awvalid_r;
    assign bus.o_axi_wdata    = wdat_r;
    assign bus.o_axi_wstrb    = wen_r;
    assign bus.o_axi_wvalid   = wvalid_r;
    assign bus.o_axi_bready   = bready_r;
    assign bus.o_axi_araddr   = adr_r;
    assign bus.o_axi_arvalid  = arvalid_r;
    assign bus.o_axi_rready   = rready_r;
endmodule

// File: tb/tb_axim_ctrl.sv
// Bench for axim_ctrl: directed and randomized requests against a behavioural slave,
// with expected responses queued at issue time and checked by a monitor on each ready pulse.
module tb_axim_ctrl;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axim_ctrl_if #(.AW(32), .DW(32)) bus ();
    axim_ctrl #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          kind;   // 0 null, 1 write, 2 read
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  wen;
        logic [31:0] rdat;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = 32'h0;
    logic        stray = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] rnd_resp();
        if ($urandom_range(0, 3) == 0) return 2'($urandom_range(1, 3));
        else return 2'b00;
    endfunction

    task automatic set_slave(input int awd, input int wd, input int ard, input int bd, input int rd,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rdat);
        aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
        bresp_cfg = br; rresp_cfg = rr; rdata_cfg = rdat;
    endtask

    // Reference model: the response follows directly from the request class and slave settings
    task automatic start_req(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] wen, input logic ren);
        exp_t e;
        e.adr = adr; e.wdat = wdat; e.wen = wen;
        if (wen != 4'h0) begin
            e.kind = 1; e.err = (bresp_cfg != 2'b00); e.rdat = 32'h0;
        end else if (ren) begin
            e.kind = 2; e.err = (rresp_cfg != 2'b00); e.rdat = rdata_cfg;
        end else begin
            e.kind = 0; e.err = 1'b0; e.rdat = 32'h0;
        end
        exp_q.push_back(e);
        bus.hs_ls4axim_val = 1'b1;
        bus.i_axim_adr     = adr;
        bus.i_axim_wdat    = wdat;
        bus.i_axim_wen     = wen;
        bus.i_axim_ren     = ren;
    endtask

    task automatic wait_rdy(output int lat);
        int  c;
        bit  seen;
        c = 0; seen = 1'b0; lat = -1;
        while (!seen && c < 200) begin
            @(negedge clk);
            if (bus.hs_axim4ls_rdy) begin
                seen = 1'b1;
                lat  = c;
            end
            c = c + 1;
        end
        if (!seen) begin
            n_cmp = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL rdy_timeout: actual no ready required ready within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Behavioural AXI4-Lite slave with per-channel wait states
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        bus.i_axi_awready = 1'b0; bus.i_axi_wready = 1'b0; bus.i_axi_arready = 1'b0;
        bus.i_axi_bvalid = 1'b0; bus.i_axi_bresp = 2'b00;
        bus.i_axi_rvalid = 1'b0; bus.i_axi_rresp = 2'b00; bus.i_axi_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                bus.i_axi_awready = 1'b0; bus.i_axi_wready = 1'b0; bus.i_axi_arready = 1'b0;
                bus.i_axi_bvalid = 1'b0; bus.i_axi_rvalid = 1'b0;
            end else begin
                if (bus.o_axi_awvalid) begin bus.i_axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin bus.i_axi_awready = 1'b0; aw_cnt = 0; end
                if (bus.o_axi_wvalid) begin bus.i_axi_wready = (w_cnt >= w_dly); w_cnt++; end
                else begin bus.i_axi_wready = 1'b0; w_cnt = 0; end
                if (bus.o_axi_arvalid) begin bus.i_axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin bus.i_axi_arready = 1'b0; ar_cnt = 0; end
                if (bus.o_axi_bready) begin
                    bus.i_axi_bvalid = (b_cnt >= b_dly); bus.i_axi_bresp = bresp_cfg; b_cnt++;
                end else begin
                    bus.i_axi_bvalid = stray; bus.i_axi_bresp = 2'b11; b_cnt = 0;
                end
                if (bus.o_axi_rready) begin
                    bus.i_axi_rvalid = (r_cnt >= r_dly); bus.i_axi_rresp = rresp_cfg;
                    bus.i_axi_rdata = rdata_cfg; r_cnt++;
                end else begin
                    bus.i_axi_rvalid = stray; bus.i_axi_rresp = 2'b10;
                    bus.i_axi_rdata = $urandom; r_cnt = 0;
                end
            end
        end
    end

    // Monitor: channel stability, per-transaction phase counts and scoreboard pop on ready
    initial begin : monitor
        int          aw_n, w_n, ar_n, b_n, r_n;
        logic        p_aw, p_w, p_ar, p_b, p_r, p_rdy;
        logic        aw_wait, w_wait, ar_wait;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        exp_t        e;
        aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
        p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; p_b = 1'b0; p_r = 1'b0; p_rdy = 1'b0;
        aw_wait = 1'b0; w_wait = 1'b0; ar_wait = 1'b0;
        aw_a = 32'h0; w_d = 32'h0; ar_a = 32'h0; w_s = 4'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
                p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0; p_b = 1'b0; p_r = 1'b0; p_rdy = 1'b0;
                aw_wait = 1'b0; w_wait = 1'b0; ar_wait = 1'b0;
            end else begin
                if (aw_wait) begin
                    chk("awvalid_held", 32'(bus.o_axi_awvalid), 32'd1);
                    chk("awaddr_stable", bus.o_axi_awaddr, aw_a);
                end
                if (w_wait) begin
                    chk("wvalid_held", 32'(bus.o_axi_wvalid), 32'd1);
                    chk("wdata_stable", bus.o_axi_wdata, w_d);
                    chk("wstrb_stable", 32'(bus.o_axi_wstrb), 32'(w_s));
                end
                if (ar_wait) begin
                    chk("arvalid_held", 32'(bus.o_axi_arvalid), 32'd1);
                    chk("araddr_stable", bus.o_axi_araddr, ar_a);
                end
                if (p_rdy) chk("rdy_one_cycle", 32'(bus.hs_axim4ls_rdy), 32'd0);
                if (bus.o_axi_awvalid && !p_aw) begin
                    aw_n++;
                    if (exp_q.size() > 0) chk("awaddr", bus.o_axi_awaddr, exp_q[0].adr);
                end
                if (bus.o_axi_wvalid && !p_w) begin
                    w_n++;
                    if (exp_q.size() > 0) begin
                        chk("wdata", bus.o_axi_wdata, exp_q[0].wdat);
                        chk("wstrb", 32'(bus.o_axi_wstrb), 32'(exp_q[0].wen));
                    end
                end
                if (bus.o_axi_arvalid && !p_ar) begin
                    ar_n++;
                    if (exp_q.size() > 0) chk("araddr", bus.o_axi_araddr, exp_q[0].adr);
                end
                if (bus.o_axi_bready && !p_b) b_n++;
                if (bus.o_axi_rready && !p_r) r_n++;
                if (bus.hs_axim4ls_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp = n_cmp + 1;
                        n_fail = n_fail + 1;
                        $display("FAIL unexpected_rdy: actual ready=1 required no ready with nothing outstanding at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("err", 32'(bus.o_axim_err), 32'(e.err));
                        if (e.kind != 1) chk("rdat", bus.o_axim_rdat, e.rdat);
                        chk("aw_phases", 32'(aw_n), (e.kind == 1) ? 32'd1 : 32'd0);
                        chk("w_phases", 32'(w_n), (e.kind == 1) ? 32'd1 : 32'd0);
                        chk("b_phases", 32'(b_n), (e.kind == 1) ? 32'd1 : 32'd0);
                        chk("ar_phases", 32'(ar_n), (e.kind == 2) ? 32'd1 : 32'd0);
                        chk("r_phases", 32'(r_n), (e.kind == 2) ? 32'd1 : 32'd0);
                    end
                    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
                end
                p_aw = bus.o_axi_awvalid; p_w = bus.o_axi_wvalid; p_ar = bus.o_axi_arvalid;
                p_b = bus.o_axi_bready; p_r = bus.o_axi_rready; p_rdy = bus.hs_axim4ls_rdy;
                aw_wait = bus.o_axi_awvalid && !bus.i_axi_awready; aw_a = bus.o_axi_awaddr;
                w_wait  = bus.o_axi_wvalid && !bus.i_axi_wready;   w_d = bus.o_axi_wdata; w_s = bus.o_axi_wstrb;
                ar_wait = bus.o_axi_arvalid && !bus.i_axi_arready; ar_a = bus.o_axi_araddr;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"}, 32'(bus.hs_axim4ls_rdy), 32'd0);
        chk({tag, "_awvalid"}, 32'(bus.o_axi_awvalid), 32'd0);
        chk({tag, "_wvalid"}, 32'(bus.o_axi_wvalid), 32'd0);
        chk({tag, "_bready"}, 32'(bus.o_axi_bready), 32'd0);
        chk({tag, "_arvalid"}, 32'(bus.o_axi_arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(bus.o_axi_rready), 32'd0);
        chk({tag, "_err"}, 32'(bus.o_axim_err), 32'd0);
        chk({tag, "_rdat"}, bus.o_axim_rdat, 32'd0);
        chk({tag, "_addr"}, bus.o_axi_awaddr, 32'd0);
        chk({tag, "_wdata"}, bus.o_axi_wdata, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual still running required completion by 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        bit seen;
        bus.hs_ls4axim_val = 1'b0;
        bus.i_axim_adr = 32'h0; bus.i_axim_wdat = 32'h0; bus.i_axim_wen = 4'h0; bus.i_axim_ren = 1'b0;
        rst = 1'b1;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait write: valids in cycle 1, bready in cycle 2, ready in cycle 3
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        start_req(32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 1'b0);
        @(negedge clk);
        chk("t1_c0_awvalid", 32'(bus.o_axi_awvalid), 32'd0);
        @(negedge clk);
        chk("t1_c1_awvalid", 32'(bus.o_axi_awvalid), 32'd1);
        chk("t1_c1_wvalid", 32'(bus.o_axi_wvalid), 32'd1);
        @(negedge clk);
        chk("t1_c2_bready", 32'(bus.o_axi_bready), 32'd1);
        @(negedge clk);
        chk("t1_c3_rdy", 32'(bus.hs_axim4ls_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.hs_ls4axim_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Read with a three-cycle arready delay
        set_slave(0, 0, 3, 0, 0, 2'b00, 2'b00, 32'h1234_5678);
        start_req(32'h2000_0000, 32'hFFFF_0000, 4'h0, 1'b1);
        wait_rdy(lat);
        chk("t2_latency", 32'(lat), 32'd6);
        bus.hs_ls4axim_val = 1'b0;

        // Write handshake orderings: W first, AW first, same cycle
        set_slave(2, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        start_req(32'h3000_0010, 32'h0102_0304, 4'h3, 1'b0);
        wait_rdy(lat);
        chk("t3a_latency", 32'(lat), 32'd5);
        bus.hs_ls4axim_val = 1'b0;
        set_slave(0, 2, 0, 0, 0, 2'b01, 2'b00, 32'h0);
        start_req(32'h3000_0020, 32'h0506_0708, 4'hC, 1'b1);
        wait_rdy(lat);
        chk("t3b_latency", 32'(lat), 32'd5);
        bus.hs_ls4axim_val = 1'b0;
        set_slave(1, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        start_req(32'h3000_0030, 32'h090A_0B0C, 4'h1, 1'b0);
        wait_rdy(lat);
        chk("t3c_latency", 32'(lat), 32'd4);
        bus.hs_ls4axim_val = 1'b0;

        // SLVERR read keeps the data, then a clean read clears err
        set_slave(0, 0, 0, 0, 1, 2'b00, 2'b10, 32'hDEAD_BEEF);
        start_req(32'h4000_0000, 32'h0, 4'h0, 1'b1);
        wait_rdy(lat);
        bus.hs_ls4axim_val = 1'b0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_F00D);
        start_req(32'h4000_0004, 32'h0, 4'h0, 1'b1);
        wait_rdy(lat);
        bus.hs_ls4axim_val = 1'b0;

        // Null request completes quickly with no bus traffic
        start_req(32'h5000_0000, 32'h7777_7777, 4'h0, 1'b0);
        wait_rdy(lat);
        chk("t5_null_quick", 32'(lat >= 1 && lat <= 2), 32'd1);
        bus.hs_ls4axim_val = 1'b0;

        // Back-to-back: next request accepted in the cycle after DONE
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_0001);
        start_req(32'h6000_0000, 32'h1111_2222, 4'hF, 1'b0);
        wait_rdy(lat);
        start_req(32'h6000_0008, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("t6_accept_cycle_arvalid", 32'(bus.o_axi_arvalid), 32'd0);
        @(negedge clk);
        chk("t6_next_arvalid", 32'(bus.o_axi_arvalid), 32'd1);
        wait_rdy(lat);
        bus.hs_ls4axim_val = 1'b0;

        // Stray responses while idle must not produce a ready
        stray = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("stray_rdy", 32'(bus.hs_axim4ls_rdy), 32'd0);
        end
        stray = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while waiting in BRESP, then a clean read
        set_slave(0, 0, 0, 100, 0, 2'b00, 2'b00, 32'h0);
        start_req(32'h7000_0000, 32'h5555_AAAA, 4'hF, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.o_axi_bready) seen = 1'b1;
            if (seen) break;
        end
        chk("t7_bready_seen", 32'(seen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t7_rst");
        exp_q.delete();
        bus.hs_ls4axim_val = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8765_4321);
        @(posedge clk);
        #1;
        start_req(32'h7000_0040, 32'h0, 4'h0, 1'b1);
        wait_rdy(lat);
        chk("t7_read_latency", 32'(lat), 32'd3);
        bus.hs_ls4axim_val = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int         k;
            logic [3:0] wen;
            logic       ren;
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), rnd_resp(), rnd_resp(), $urandom);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                wen = 4'h0; ren = 1'b0;
            end else if (k < 5) begin
                wen = 4'($urandom_range(1, 15)); ren = 1'($urandom_range(0, 1));
            end else begin
                wen = 4'h0; ren = 1'b1;
            end
            start_req($urandom, $urandom, wen, ren);
            wait_rdy(lat);
            if ($urandom_range(0, 1) == 1) begin
                bus.hs_ls4axim_val = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.hs_ls4axim_val = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
